// File: rtl/dl_rr_arbiter.sv
// Round-robin arbiter with rotating priority pointer and optional grant lock.
// Grants are registered; no combinational path from req/hold to outputs.
module dl_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               hold,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [NUM_REQ-1:0] r_gnt;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_ptr;

    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_pos;
    logic               w_found;
    logic               w_lock;
    logic [NUM_REQ-1:0] w_onehot;

    // First set request at or after r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = IDX_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_pos]) begin
                w_found = 1'b1;
                w_win   = w_pos;
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_win] = 1'b1;
    end

    assign w_lock = r_valid & hold & req[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else if (!w_lock) begin
            if (w_found) begin
                r_gnt   <= w_onehot;
                r_valid <= 1'b1;
                r_idx   <= w_win;
                r_ptr   <= (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + IDX_W'(1);
            end else begin
                r_gnt   <= '0;
                r_valid <= 1'b0;
                r_idx   <= '0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_valid;
    assign gnt_idx   = r_idx;

    a_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_valid   : assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));
    a_idx     : assert property (@(posedge clk) disable iff (rst)
                    gnt_valid ? (gnt == (NUM_REQ'(1) << gnt_idx)) : (gnt_idx == '0));
    a_req     : assert property (@(posedge clk) disable iff (rst) (gnt & ~$past(req)) == '0);

endmodule

// File: tb/tb_dl_rr_arbiter.sv
// Self-checking bench: directed plan plus random traffic against a rule-level
// reference model, for a 4-requester and a 1-requester instance.
module tb_dl_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req4;
    logic       hold4;
    logic [3:0] gnt4;
    logic       gv4;
    logic [1:0] gi4;
    logic [0:0] req1;
    logic       hold1;
    logic [0:0] gnt1;
    logic       gv1;
    logic [0:0] gi1;

    int checks = 0;
    int errors = 0;

    // Reference model state: granted index (valid flag) and next-priority index.
    int m_ptr;
    int m_idx;
    bit m_valid;
    bit m1;

    dl_rr_arbiter #(.NUM_REQ(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req4), .hold(hold4),
        .gnt(gnt4), .gnt_valid(gv4), .gnt_idx(gi4)
    );

    dl_rr_arbiter #(.NUM_REQ(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .hold(hold1),
        .gnt(gnt1), .gnt_valid(gv1), .gnt_idx(gi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_idx   = 0;
        m_valid = 0;
        m1      = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic h, input logic r1);
        if (m_valid && h && r[m_idx]) begin
            // locked: nothing changes
        end else if (r == 4'b0000) begin
            m_valid = 0;
            m_idx   = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (r[j]) begin
                    m_idx   = j;
                    m_valid = 1;
                    m_ptr   = (j + 1) % 4;
                    break;
                end
            end
        end
        m1 = r1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt4"}, 32'(gnt4), 32'd0);
        check({tag, "_gv4"},  32'(gv4),  32'd0);
        check({tag, "_gi4"},  32'(gi4),  32'd0);
        check({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        check({tag, "_gv1"},  32'(gv1),  32'd0);
        check({tag, "_gi1"},  32'(gi1),  32'd0);
    endtask

    task automatic cycle(input logic [3:0] r, input logic h, input logic r1, input logic h1);
        logic [3:0] exp_gnt;
        req4  = r;
        hold4 = h;
        req1  = r1;
        hold1 = h1;
        @(posedge clk);
        model_edge(r, h, r1);
        #1;
        exp_gnt = m_valid ? 4'(1 << m_idx) : 4'b0000;
        check("gnt4", 32'(gnt4), 32'(exp_gnt));
        check("gv4",  32'(gv4),  32'(m_valid));
        check("gi4",  32'(gi4),  32'(m_idx));
        check("gnt1", 32'(gnt1), 32'(m1));
        check("gv1",  32'(gv1),  32'(m1));
        check("gi1",  32'(gi1),  32'd0);
    endtask

    // Called just after a rising edge; reset must clear outputs before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] tbl [5];

    initial begin
        tbl   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst   = 1'b0;
        req4  = 'x;
        hold4 = 1'b0;
        req1  = 'x;
        hold1 = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        repeat (2) @(posedge clk);
        #1 check_zero("rst_hold_x");
        req4 = 4'b0000;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Rotation; the single-requester instance sees 1,0,1 with hold=1
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b0, (i != 1), 1'b1);
            check("t1_tbl", 32'(gnt4), 32'(tbl[i]));
        end

        // Sparse requests
        do_reset();
        repeat (4) cycle(4'b1010, 1'b0, 1'b1, 1'b1);

        // Lock and release
        do_reset();
        repeat (3) cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            cycle(4'b1111, 1'b1, 1'b1, 1'b1);
            check("t3_lock", 32'(gnt4), 32'b0100);
        end
        cycle(4'b1011, 1'b1, 1'b0, 1'b1);
        check("t3_release", 32'(gi4), 32'd3);

        // Idle preserves pointer
        do_reset();
        cycle(4'b0010, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1, 1'b0);
        check("t4_resume", 32'(gnt4), 32'b0100);

        // Async reset mid-operation, then first grant goes to requester 0
        do_reset();
        repeat (4) cycle(4'b1111, 1'b0, 1'b1, 1'b0);
        check("t5_pre", 32'(gnt4), 32'b1000);
        do_reset();
        cycle(4'b1111, 1'b0, 1'b1, 1'b0);
        check("t5_post", 32'(gnt4), 32'b0001);

        // Random traffic with frequent hold
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dl_rr_arbiter.md
Name: dl_rr_arbiter

Overview:
- Parameterized round-robin arbiter for the design library.
- Takes a request vector from NUM_REQ sources and produces a registered one-hot grant to at most one of them.
- Rotating priority gives fair sharing; an optional hold input locks a grant for multi-cycle transfers.
- Intended for shared-resource access in the core: memory port sharing, writeback-port contention, bus masters.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..32.
- IDX_W, derived localparam (not overridable): max(1, clog2(NUM_REQ)); width of the index output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_REQ  request vector; bit i high means requester i wants the resource.
- hold  input  1  when high, keeps the current grant while its requester still requests.
- gnt  output  NUM_REQ  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  registered; high whenever gnt is non-zero.
- gnt_idx  output  IDX_W  registered binary index of the granted requester; 0 when idle.

Behaviour:
- Internal state: priority pointer ptr (IDX_W bits), plus the gnt, gnt_valid and gnt_idx registers.
- Reset, asserted at any time and independent of clk:
  - gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, immediately.
  - Holds while rst is high.
  - First arbitration happens on the first rising edge after rst deasserts.
- Latency: req sampled at edge t is reflected in gnt/gnt_valid/gnt_idx after edge t (one cycle, registered). No combinational path from req or hold to any output.
- Per-edge decision, in priority order:
  1. Lock. If gnt_valid=1, hold=1 and req[gnt_idx]=1, all outputs and ptr are unchanged.
  2. Arbitrate. Otherwise scan req starting at index ptr, upward, wrapping from NUM_REQ-1 to 0. The first set bit w wins:
     - gnt = one-hot(w), gnt_idx = w, gnt_valid = 1.
     - ptr = (w+1) mod NUM_REQ. When w = NUM_REQ-1, ptr wraps to 0.
  3. Idle. If req=0: gnt=0, gnt_valid=0, gnt_idx=0, ptr unchanged.
- Hold ignored when not applicable:
  - hold is ignored when gnt_valid=0.
  - hold is ignored when the granted requester has dropped req. Arbitration proceeds in that same edge, so there is no idle bubble.
- Fairness: with hold=0 and all requesters continuously requesting, each is granted exactly once every NUM_REQ cycles.
- A requester granted last cycle with hold=0 may be granted again only if no other requester is asserting.
- Invariants, checked by assertion:
  - gnt is always one-hot or zero.
  - gnt_valid equals the OR-reduction of gnt.
  - gnt_idx matches the set bit of gnt.
  - gnt[i]=1 implies req[i] was 1 at the deciding edge.
- NUM_REQ=1:
  - ptr is constant 0 and gnt_idx is constant 0.
  - gnt = req delayed one cycle; hold has no observable effect.
- X on req while rst=1 must not propagate to outputs.

Test Plan:
1. Rotation: reset, then req=4'b1111, hold=0 held 5 cycles -> gnt=0001,0010,0100,1000,0001 on successive edges; gnt_idx=0,1,2,3,0; gnt_valid=1 throughout.
2. Sparse requests: after reset, req=4'b1010, hold=0 -> gnt=0010, 1000, 0010, 1000; ptr wraps 2->0->2->0.
3. Lock and release:
   - Reach gnt=0100, then set hold=1 with req=4'b1111 for 5 cycles -> gnt stays 0100, ptr stays 3.
   - Then drop req[2] with hold=1 -> next edge gnt=1000, gnt_idx=3.
4. Idle preserves pointer: grant idx1 (ptr=2), then req=0 for 3 cycles -> gnt=0, gnt_valid=0, gnt_idx=0; then req=4'b1111 -> gnt=0100.
5. Async reset mid-operation:
   - Assert rst between clock edges while gnt=1000 -> gnt=0, gnt_valid=0, gnt_idx=0 before the next edge.
   - Release rst with req=4'b1111 -> first grant 0001.
6. NUM_REQ=1 instance: req toggles 1,0,1 -> gnt=1,0,1 one cycle later; gnt_idx=0 always; hold=1 has no effect.
